seg7_display_ctrl: RTL and testbench
====================================

// Module: seg7_display_ctrl
// PURPOSE
// - CPU-write side of the seven-segment display I/O: memory-mapped 32-bit display register written by CPU store cycles.
// - Time-multiplexes the 8 hex digits onto the board's shared segment lines.
// - Register contents return on rdata, which feeds the CPU read-data select path.
// PARAMETERS
// - SCAN_DIV   100000   clock cycles each digit stays lit; legal range 1..2^24
// PORTS
// - clk     in   1   system clock, rising edge
// - rst     in   1   synchronous, active-high reset
// - cs      in   1   chip select; display register addressed this cycle
// - we      in   1   write enable from CPU store
// - wdata   in   32  CPU write data; nibble i = digit i, digit 0 rightmost
// - rdata   out  32  current display register, combinational from register
// - an      out  8   digit enables, active-low; an[i] drives digit i
// - seg     out  8   segments, active-low; seg[7]=dp, seg[6:0]={g,f,e,d,c,b,a}
// BEHAVIOUR
// - Clock and reset: one clock domain (clk); reset is synchronous and active-high (rst), sampled on the rising edge of clk.
// - Reset values: disp_reg=0, scan counter=0, digit index=0, an=8'hFF, seg=8'hFF (all dark); rdata=0.
// - Write:
//   - cs&&we at edge N loads wdata into disp_reg; rdata shows it after edge N.
//   - The first segment output using the new value appears after edge N+1.
//   - Any other cs/we combination leaves disp_reg unchanged.
// - Scan counter: counts 0..SCAN_DIV-1 every cycle; on terminal count it returns to 0 and the digit index increments 7->0 (mod 8).
// - SCAN_DIV=1: digit index advances every cycle.
// - Writes never reset or stall the counter or the digit index.
// - Output stage: registered, one cycle after index/disp_reg.
//   - an <= ~(8'b1 << idx).
//   - seg <= {1'b1, hex7(disp_reg[4*idx+:4])}; dp is always off.
// - hex7, active-low, seg[6:0]:
//   - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
//   - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
// - Exactly one an bit is low in every cycle after the first post-reset cycle; never 0 or >=2 low.
// - Reset mid-scan: on the reset edge all state returns to reset values; the first cycle after reset release shows an=FE.
// - Simultaneous write and digit advance: the new index is displayed with the new data (both sampled from registers at the same edge).
// CONFIGURATION
// - SEG7_LZ_BLANK_EN defined: leading-zero blanking.
//   - Digit i (i>0) is blank (seg=8'hFF, an unchanged) when disp_reg[31:4*i]==0.
//   - Digit 0 is never blanked; value 0 displays a single "0".
// - SEG7_LZ_BLANK_EN undefined: all 8 digits always displayed, leading zeros shown as "0".
// TESTING
// - Reset: rst=1 for 2 cycles -> an=FF, seg=FF, rdata=0.
//   - First cycle after release -> an=FE, seg=C0.
// - Write 32'h12345678 (cs=1, we=1), SCAN_DIV=4 -> rdata=12345678 next cycle; digit0 seg=80 (8) with an=FE.
//   - Each 4 cycles an steps FE,FD,FB,...,7F; digit7 shows seg=F9 (1).
// - Wrap: continue after an=7F -> next step an=FE; no cycle with an=FF or multiple low bits.
// - Write with cs=0, we=1, wdata=FFFFFFFF -> rdata and seg unchanged.
//   - Write mid-digit (counter=2) -> counter phase unchanged; next output seg reflects new nibble.
// - Reset asserted mid-scan at idx=5 -> next cycle an=FF, seg=FF, rdata=0; scan restarts at digit 0.
// - SEG7_LZ_BLANK_EN, write 32'h000000A5:
//   - digit0 seg=92, digit1 seg=88; digits 2..7 seg=FF with an still stepping.
//   - Write 0 -> only digit0 lit, seg=C0.

Source files
------------

// File: rtl/seg7_display_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_display_ctrl
//
// Memory-mapped 32-bit seven-segment display register with a time-multiplexed
// scan of its 8 hex digits onto the board's shared segment lines.
//
// A CPU store (cs && we) loads the display register. The register is read back
// combinationally on rdata for the CPU read-data select path. A free-running
// scan counter holds each digit lit for SCAN_DIV cycles before the digit index
// advances (7 wraps to 0). The digit enables and segment lines are registered
// one cycle after the index and display register they are decoded from.
//
// Parameters:
//   SCAN_DIV  cycles each digit stays lit, legal range 1..2^24
//
// Ports:
//   clk    in   1   system clock, rising edge
//   rst    in   1   synchronous, active-high reset
//   cs     in   1   chip select; display register addressed this cycle
//   we     in   1   write enable from CPU store
//   wdata  in   32  write data; nibble i = digit i, digit 0 rightmost
//   rdata  out  32  current display register
//   an     out  8   digit enables, active-low; an[i] drives digit i
//   seg    out  8   segments, active-low; seg[7]=dp, seg[6:0]={g,f,e,d,c,b,a}
//
// Build option:
//   SEG7_LZ_BLANK_EN  when defined, leading-zero digits above digit 0 are
//                     blanked (seg=8'hFF) while an keeps stepping. When
//                     undefined, every digit is always displayed.
// -----------------------------------------------------------------------------
module seg7_display_ctrl #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  // SCAN_DIV=1 would give a zero-width counter; keep one bit that stays at 0.
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [31:0]      disp_reg, disp_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       idx_reg, idx_next;
  logic [7:0]       an_reg, an_next;
  logic [7:0]       seg_reg, seg_next;

  logic [3:0]       digit_nib [8];

  // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_nib
      assign digit_nib[gi] = disp_reg[4*gi +: 4];
    end
  endgenerate

`ifdef SEG7_LZ_BLANK_EN
  // zero_above[i]: every nibble from digit i upward is zero, so digit i is a
  // leading zero. Digit 0 is never blanked so a zero value still shows "0".
  logic [7:0] zero_above;
  assign zero_above[0] = 1'b0;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_lz
      assign zero_above[gi] = (disp_reg[31:4*gi] == '0);
    end
  endgenerate
`endif

  // Register write: only a selected store updates the display value.
  always_comb begin
    disp_next = disp_reg;
    if (cs && we) begin
      disp_next = wdata;
    end
  end

  // Scan timing: writes have no influence on the counter or digit index.
  always_comb begin
    cnt_next = cnt_reg + CNT_W'(1);
    idx_next = idx_reg;
    if (cnt_reg == CNT_MAX) begin
      cnt_next = '0;
      idx_next = idx_reg + 3'd1;
    end
  end

  // Output decode from the current registers; a write and a digit advance on
  // the same edge are therefore both visible in the next decode together.
  always_comb begin
    an_next  = ~(8'h01 << idx_reg);
    seg_next = {1'b1, hex7(digit_nib[idx_reg])};
`ifdef SEG7_LZ_BLANK_EN
    if (zero_above[idx_reg]) begin
      seg_next = 8'hFF;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_reg <= '0;
      cnt_reg  <= '0;
      idx_reg  <= '0;
      an_reg   <= 8'hFF;
      seg_reg  <= 8'hFF;
    end else begin
      disp_reg <= disp_next;
      cnt_reg  <= cnt_next;
      idx_reg  <= idx_next;
      an_reg   <= an_next;
      seg_reg  <= seg_next;
    end
  end

  assign rdata = disp_reg;
  assign an    = an_reg;
  assign seg   = seg_reg;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_display_ctrl
//
// Directed bench for seg7_display_ctrl with SCAN_DIV=4. Inputs are driven and
// outputs sampled on the falling edge of clk. Edge numbering in comments counts
// rising edges after reset release (E1 is the first non-reset edge).
// -----------------------------------------------------------------------------
module tb_seg7_display_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  an;
  logic [7:0]  seg;

  int checks   = 0;
  int failures = 0;

  // Expected segment bytes (dp off) for data 32'h12345678, digit 0..7.
  logic [7:0] exp_seg_main [8] = '{8'h80, 8'hF8, 8'h82, 8'h92,
                                   8'h99, 8'hB0, 8'hA4, 8'hF9};

  seg7_display_ctrl #(.SCAN_DIV(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .cs    (cs),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .an    (an),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_write(input logic [31:0] d);
    cs = 1'b1; we = 1'b1; wdata = d;
    $display("write wdata=%08h", d);
    step(1);
    cs = 1'b0; we = 1'b0;
  endtask

  // Reset for two cycles, then release; ends at negedge after E1.
  task automatic test_reset;
    rst = 1'b1; cs = 1'b0; we = 1'b0; wdata = '0;
    step(2);
    checks++; if (an !== 8'hFF) begin failures++; $display("FAIL reset_an got=%02h exp=FF", an); end
    checks++; if (seg !== 8'hFF) begin failures++; $display("FAIL reset_seg got=%02h exp=FF", seg); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%08h exp=0", rdata); end
    rst = 1'b0;
    step(1);
    checks++; if (an !== 8'hFE) begin failures++; $display("FAIL release_an got=%02h exp=FE", an); end
    checks++; if (seg !== 8'hC0) begin failures++; $display("FAIL release_seg got=%02h exp=C0", seg); end
  endtask

  // Write at E2, full scan of digits 1..7 checked every cycle; ends after E33.
  task automatic test_write_scan;
    logic [7:0] exp_an;
    cpu_write(32'h12345678);                       // now after E2
    checks++; if (rdata !== 32'h12345678) begin failures++; $display("FAIL write_rdata got=%08h exp=12345678", rdata); end
    step(1);                                       // E3: digit0 with new data
    checks++; if (an !== 8'hFE) begin failures++; $display("FAIL d0_an got=%02h exp=FE", an); end
    checks++; if (seg !== 8'h80) begin failures++; $display("FAIL d0_seg got=%02h exp=80", seg); end
    step(2);                                       // E5: digit1 begins
    for (int k = 1; k < 8; k++) begin
      exp_an = ~(8'h01 << k);
      for (int c = 0; c < 4; c++) begin
        checks++; if (an !== exp_an) begin failures++; $display("FAIL scan_an digit=%0d cyc=%0d got=%02h exp=%02h", k, c, an, exp_an); end
        checks++; if (seg !== exp_seg_main[k]) begin failures++; $display("FAIL scan_seg digit=%0d cyc=%0d got=%02h exp=%02h", k, c, seg, exp_seg_main[k]); end
        step(1);
      end
    end
  endtask

  // After digit7 the scan returns to digit0 (at E33).
  task automatic test_wrap;
    checks++; if (an !== 8'hFE) begin failures++; $display("FAIL wrap_an got=%02h exp=FE", an); end
    checks++; if (seg !== 8'h80) begin failures++; $display("FAIL wrap_seg got=%02h exp=80", seg); end
  endtask

  // Unselected store and selected read leave the register alone (E34, E35).
  task automatic test_no_write;
    cs = 1'b0; we = 1'b1; wdata = 32'hFFFFFFFF;
    $display("store cs=0 we=1 wdata=%08h", wdata);
    step(1);
    cs = 1'b1; we = 1'b0;
    $display("access cs=1 we=0 wdata=%08h", wdata);
    step(1);
    cs = 1'b0; we = 1'b0;
    checks++; if (rdata !== 32'h12345678) begin failures++; $display("FAIL nowrite_rdata got=%08h exp=12345678", rdata); end
    checks++; if (seg !== 8'h80) begin failures++; $display("FAIL nowrite_seg got=%02h exp=80", seg); end
    checks++; if (an !== 8'hFE) begin failures++; $display("FAIL nowrite_an got=%02h exp=FE", an); end
  endtask

  // Write while digit1 is showing with counter=2 (written at E39).
  task automatic test_mid_digit_write;
    step(3);                                       // E38: digit1, cnt=2
    checks++; if (seg !== 8'hF8) begin failures++; $display("FAIL mid_pre_seg got=%02h exp=F8", seg); end
    cpu_write(32'h123456A8);                       // E39
    checks++; if (rdata !== 32'h123456A8) begin failures++; $display("FAIL mid_rdata got=%08h exp=123456A8", rdata); end
    checks++; if (seg !== 8'hF8) begin failures++; $display("FAIL mid_old_seg got=%02h exp=F8", seg); end
    step(1);                                       // E40: still digit1, new nibble
    checks++; if (an !== 8'hFD) begin failures++; $display("FAIL mid_an got=%02h exp=FD", an); end
    checks++; if (seg !== 8'h88) begin failures++; $display("FAIL mid_new_seg got=%02h exp=88", seg); end
    step(1);                                       // E41: digit2, phase unchanged
    checks++; if (an !== 8'hFB) begin failures++; $display("FAIL mid_next_an got=%02h exp=FB", an); end
    checks++; if (seg !== 8'h82) begin failures++; $display("FAIL mid_next_seg got=%02h exp=82", seg); end
  endtask

  // Reset with index at 5 (index reaches 5 at E52).
  task automatic test_reset_mid_scan;
    step(10);                                      // E51: digit4 shown
    checks++; if (an !== 8'hEF) begin failures++; $display("FAIL pre_rst_an got=%02h exp=EF", an); end
    step(1);                                       // E52: idx now 5
    rst = 1'b1;
    $display("reset asserted mid-scan");
    step(1);
    checks++; if (an !== 8'hFF) begin failures++; $display("FAIL midrst_an got=%02h exp=FF", an); end
    checks++; if (seg !== 8'hFF) begin failures++; $display("FAIL midrst_seg got=%02h exp=FF", seg); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL midrst_rdata got=%08h exp=0", rdata); end
    rst = 1'b0;
    step(1);                                       // new E1
    checks++; if (an !== 8'hFE) begin failures++; $display("FAIL restart_an got=%02h exp=FE", an); end
    checks++; if (seg !== 8'hC0) begin failures++; $display("FAIL restart_seg got=%02h exp=C0", seg); end
    step(3);                                       // E4: digit0 still
    checks++; if (an !== 8'hFE) begin failures++; $display("FAIL restart_hold_an got=%02h exp=FE", an); end
    step(1);                                       // E5: digit1
    checks++; if (an !== 8'hFD) begin failures++; $display("FAIL restart_step_an got=%02h exp=FD", an); end
    checks++; if (seg !== 8'hC0) begin failures++; $display("FAIL restart_step_seg got=%02h exp=C0", seg); end
  endtask

  // Leading-zero behaviour for 32'h000000A5 and for 0.
  task automatic test_leading_zero;
    logic [7:0] exp_an;
    logic [7:0] exp_hi;
`ifdef SEG7_LZ_BLANK_EN
    exp_hi = 8'hFF;
`else
    exp_hi = 8'hC0;
`endif
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);                                       // E1
    cpu_write(32'h000000A5);                       // E2
    step(1);                                       // E3: digit0
    checks++; if (seg !== 8'h92) begin failures++; $display("FAIL lz_d0_seg got=%02h exp=92", seg); end
    step(2);                                       // E5: digit1
    checks++; if (seg !== 8'h88) begin failures++; $display("FAIL lz_d1_seg got=%02h exp=88", seg); end
    checks++; if (an !== 8'hFD) begin failures++; $display("FAIL lz_d1_an got=%02h exp=FD", an); end
    step(4);
    for (int k = 2; k < 8; k++) begin
      exp_an = ~(8'h01 << k);
      checks++; if (an !== exp_an) begin failures++; $display("FAIL lz_an digit=%0d got=%02h exp=%02h", k, an, exp_an); end
      checks++; if (seg !== exp_hi) begin failures++; $display("FAIL lz_seg digit=%0d got=%02h exp=%02h", k, seg, exp_hi); end
      step(4);
    end                                            // now E33: digit0
    cpu_write(32'h0);                              // E34
    step(1);                                       // E35
    checks++; if (seg !== 8'hC0) begin failures++; $display("FAIL zero_d0_seg got=%02h exp=C0", seg); end
    checks++; if (an !== 8'hFE) begin failures++; $display("FAIL zero_d0_an got=%02h exp=FE", an); end
    step(2);                                       // E37: digit1 onwards
    for (int k = 1; k < 8; k++) begin
      exp_an = ~(8'h01 << k);
      checks++; if (an !== exp_an) begin failures++; $display("FAIL zero_an digit=%0d got=%02h exp=%02h", k, an, exp_an); end
      checks++; if (seg !== exp_hi) begin failures++; $display("FAIL zero_seg digit=%0d got=%02h exp=%02h", k, seg, exp_hi); end
      step(4);
    end
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; we = 1'b0; wdata = '0;
    @(negedge clk);
    test_reset;
    test_write_scan;
    test_wrap;
    test_no_write;
    test_mid_digit_write;
    test_reset_mid_scan;
    test_leading_zero;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
